// File: rtl/multi_interval_timer.sv
// N-channel prescaled interval timer on an Avalon-MM slave; timeout pulse and IRQ per channel, ORed system IRQ.
// Read data registered (1 cycle, no wait states); writes always accepted; timer outputs combinational from registered state.
module multi_interval_timer #(
    parameter int NUM_CH         = 4,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8,
    parameter int DEFAULT_PERIOD = 49999
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2+$clog2(NUM_CH):0] address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [15:0]               writedata,
    output logic [15:0]               readdata,
    output logic                      irq,
    output logic [NUM_CH-1:0]         irq_vec,
    output logic [NUM_CH-1:0]         pulse_out
);
    localparam int AW  = 3 + $clog2(NUM_CH);
    localparam int CHW = AW - 2;  // channel field plus a guard bit, never zero width
    localparam int CW  = COUNTER_WIDTH;
    localparam int PW  = PRESCALE_WIDTH;
    localparam logic [CW-1:0] DEF = CW'(DEFAULT_PERIOD);

    logic [CW-1:0]     counter_q  [NUM_CH];
    logic [CW-1:0]     counter_d  [NUM_CH];
    logic [CW-1:0]     period_q   [NUM_CH];
    logic [CW-1:0]     period_d   [NUM_CH];
    logic [CW-1:0]     snap_q     [NUM_CH];
    logic [CW-1:0]     snap_d     [NUM_CH];
    logic [PW-1:0]     prescale_q [NUM_CH];
    logic [PW-1:0]     prescale_d [NUM_CH];
    logic [PW-1:0]     pre_q      [NUM_CH];
    logic [PW-1:0]     pre_d      [NUM_CH];
    logic [3:0]        control_q  [NUM_CH];
    logic [3:0]        control_d  [NUM_CH];
    logic [NUM_CH-1:0] running_q, running_d;
    logic [NUM_CH-1:0] timeout_q, timeout_d;
    logic [NUM_CH-1:0] zero_q, zero_d;
    logic [NUM_CH-1:0] force_q, force_d;
    logic [NUM_CH-1:0] wr_ch, ev;
    logic [15:0]       readdata_q, readdata_d, rd_mux;

    logic [AW:0]      addr_ext;
    logic [CHW-1:0]   ch_sel;
    logic [2:0]       reg_sel;
    logic             wr_en, rd_en;

    assign addr_ext = {1'b0, address};
    assign ch_sel   = addr_ext[AW:3];
    assign reg_sel  = address[2:0];
    assign wr_en    = chipselect & ~write_n;
    assign rd_en    = chipselect & write_n;

    always_comb begin
        wr_ch     = '0;
        ev        = '0;
        running_d = running_q;
        timeout_d = timeout_q;
        zero_d    = zero_q;
        force_d   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            counter_d[ch]  = counter_q[ch];
            period_d[ch]   = period_q[ch];
            snap_d[ch]     = snap_q[ch];
            prescale_d[ch] = prescale_q[ch];
            pre_d[ch]      = pre_q[ch];
            control_d[ch]  = control_q[ch];
            wr_ch[ch]      = wr_en && (ch_sel == CHW'(ch));
            ev[ch]         = (counter_q[ch] == '0) && !zero_q[ch];
            zero_d[ch]     = (counter_q[ch] == '0);

            if (force_q[ch]) begin
                counter_d[ch] = period_q[ch];
                pre_d[ch]     = prescale_q[ch];
                running_d[ch] = 1'b0;
            end else if (running_q[ch]) begin
                if (pre_q[ch] == '0) begin
                    pre_d[ch] = prescale_q[ch];
                    // a tick at zero reloads instead of decrementing; one-shot stops here
                    if (counter_q[ch] == '0) begin
                        counter_d[ch] = period_q[ch];
                        if (!control_q[ch][1]) running_d[ch] = 1'b0;
                    end else begin
                        counter_d[ch] = counter_q[ch] - CW'(1);
                    end
                end else begin
                    pre_d[ch] = pre_q[ch] - PW'(1);
                end
            end

            if (ev[ch]) timeout_d[ch] = 1'b1;

            if (wr_ch[ch]) begin
                case (reg_sel)
                    3'd0: if (!ev[ch]) timeout_d[ch] = 1'b0;
                    3'd1: begin
                        control_d[ch] = writedata[3:0];
                        if (writedata[2]) begin
                            running_d[ch] = 1'b1;
                            pre_d[ch]     = prescale_q[ch];
                        end else if (writedata[3]) begin
                            running_d[ch] = 1'b0;
                        end
                    end
                    3'd2: begin
                        period_d[ch][15:0] = writedata;
                        force_d[ch]        = 1'b1;
                    end
                    3'd3: begin
                        period_d[ch][CW-1:16] = writedata[CW-17:0];
                        force_d[ch]           = 1'b1;
                    end
                    3'd4, 3'd5: snap_d[ch] = counter_q[ch];
                    3'd6: prescale_d[ch] = writedata[PW-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (ch_sel == CHW'(ch)) begin
                case (reg_sel)
                    3'd0: rd_mux = {14'b0, running_q[ch], timeout_q[ch]};
                    3'd1: rd_mux = {12'b0, control_q[ch]};
                    3'd2: rd_mux = period_q[ch][15:0];
                    3'd3: rd_mux = 16'(period_q[ch] >> 16);
                    3'd4: rd_mux = snap_q[ch][15:0];
                    3'd5: rd_mux = 16'(snap_q[ch] >> 16);
                    3'd6: rd_mux = 16'(prescale_q[ch]);
                    default: rd_mux = '0;
                endcase
            end
        end
        readdata_d = rd_en ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                counter_q[ch]  <= DEF;
                period_q[ch]   <= DEF;
                snap_q[ch]     <= '0;
                prescale_q[ch] <= '0;
                pre_q[ch]      <= '0;
                control_q[ch]  <= '0;
            end
            running_q  <= '0;
            timeout_q  <= '0;
            zero_q     <= {NUM_CH{DEF == '0}};
            force_q    <= '0;
            readdata_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                counter_q[ch]  <= counter_d[ch];
                period_q[ch]   <= period_d[ch];
                snap_q[ch]     <= snap_d[ch];
                prescale_q[ch] <= prescale_d[ch];
                pre_q[ch]      <= pre_d[ch];
                control_q[ch]  <= control_d[ch];
            end
            running_q  <= running_d;
            timeout_q  <= timeout_d;
            zero_q     <= zero_d;
            force_q    <= force_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        pulse_out = ev;
        irq_vec   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) irq_vec[ch] = timeout_q[ch] & control_q[ch][0];
    end

    assign irq      = |irq_vec;
    assign readdata = readdata_q;
endmodule

// File: tb/tb_multi_interval_timer.sv
// Randomized bench for multi_interval_timer; expected timing comes from period/prescale arithmetic.
module tb_multi_interval_timer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [3:0]  irq_vec;
    logic [3:0]  pulse_out;

    int total = 0;
    int passed = 0;
    int edge_cnt = 0;

    multi_interval_timer dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec), .pulse_out(pulse_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // Pulse k edges after the start write: first zero after P ticks, then every P+1 ticks.
    function automatic bit m_pulse(input int k, input int p, input int s, input bit cont);
        int first, per;
        first = p * (s + 1);
        per   = (p + 1) * (s + 1);
        if (k < first) return 1'b0;
        if (!cont) return (k == first);
        return ((k - first) % per) == 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(input int t);
        while (edge_cnt < t) idle(1);
    endtask

    task automatic wr(input int ch, input int r, input logic [15:0] d);
        address = 5'(ch * 8 + r); chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input int ch, input int r, output logic [15:0] d);
        address = 5'(ch * 8 + r); chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        d = readdata; chipselect = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic program_ch(input int ch, input int p, input int s);
        logic [31:0] pv;
        pv = p;
        wr(ch, 2, pv[15:0]);
        wr(ch, 3, pv[31:16]);
        wr(ch, 6, 16'(s));
    endtask

    task automatic test_reset;
        logic [15:0] d, e;
        do_reset;
        total++; if ({irq, irq_vec, pulse_out} !== 9'b0) $display("FAIL reset_outputs: got %b want 0", {irq, irq_vec, pulse_out}); else passed++;
        total++; if (readdata !== 16'h0) $display("FAIL reset_readdata: got %h want 0", readdata); else passed++;
        for (int r = 0; r < 8; r++) begin
            rd(0, r, d);
            e = (r == 2) ? 16'hC34F : 16'h0000;
            total++; if (d !== e) $display("FAIL reset_reg%0d: got %h want %h", r, d, e); else passed++;
        end
    endtask

    task automatic test_continuous;
        int p, s, st, first, per, k;
        logic [15:0] d;
        logic [3:0] ep;
        do_reset;
        p = $urandom_range(5, 12); s = $urandom_range(0, 1);
        first = p * (s + 1); per = (p + 1) * (s + 1);
        program_ch(1, p, s);
        wr(1, 1, 16'h7); st = edge_cnt;
        for (int i = 1; i <= first + 2 * per + 1; i++) begin
            idle(1);
            k = edge_cnt - st;
            ep = {2'b0, m_pulse(k, p, s, 1'b1), 1'b0};
            total++; if (pulse_out !== ep) $display("FAIL cont_pulse k=%0d: got %b want %b", k, pulse_out, ep); else passed++;
            total++; if (irq !== (k > first)) $display("FAIL cont_irq k=%0d: got %b want %b", k, irq, k > first); else passed++;
        end
        wr(1, 0, 16'h0);
        while (1) begin
            k = edge_cnt - st;
            total++; if (irq !== (k > first + 3 * per)) $display("FAIL cont_irq_clear k=%0d: got %b want %b", k, irq, k > first + 3 * per); else passed++;
            if (k >= first + 3 * per + 1) break;
            idle(1);
        end
        wr(1, 1, 16'h8);
        rd(1, 0, d);
        total++; if (d !== 16'h0001) $display("FAIL cont_stop_status: got %h want 0001", d); else passed++;
        rd(1, 1, d);
        total++; if (d !== 16'h0008) $display("FAIL cont_control_rb: got %h want 0008", d); else passed++;
    endtask

    task automatic test_oneshot;
        int p, s, first, per, st, k;
        logic [15:0] d;
        logic [3:0] ep;
        do_reset;
        p = $urandom_range(2, 6); s = $urandom_range(0, 3);
        first = p * (s + 1); per = (p + 1) * (s + 1);
        program_ch(2, p, s);
        wr(2, 1, 16'h5); st = edge_cnt;
        for (int i = 1; i <= first + 2 * per + 4; i++) begin
            idle(1);
            k = edge_cnt - st;
            ep = {1'b0, m_pulse(k, p, s, 1'b0), 2'b0};
            total++; if (pulse_out !== ep) $display("FAIL oneshot_pulse k=%0d: got %b want %b", k, pulse_out, ep); else passed++;
        end
        rd(2, 0, d);
        total++; if (d !== 16'h0001) $display("FAIL oneshot_status: got %h want 0001", d); else passed++;
        wr(2, 4, 16'h0);
        rd(2, 4, d);
        total++; if (d !== 16'(p)) $display("FAIL oneshot_hold: got %h want %h", d, 16'(p)); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL oneshot_irq: got %b want 1", irq); else passed++;
    endtask

    task automatic test_snapshot;
        int p, st, q;
        logic [31:0] ex;
        logic [15:0] d;
        do_reset;
        p = 32'h10000 + $urandom_range(0, 65535);
        program_ch(0, p, 0);
        wr(0, 1, 16'h6); st = edge_cnt;
        idle($urandom_range(90, 110));
        wr(0, 4, 16'h0);
        ex = p - (edge_cnt - 1 - st);
        rd(0, 4, d);
        total++; if (d !== ex[15:0]) $display("FAIL snap_big_l: got %h want %h", d, ex[15:0]); else passed++;
        rd(0, 5, d);
        total++; if (d !== ex[31:16]) $display("FAIL snap_big_h: got %h want %h", d, ex[31:16]); else passed++;
        idle(7);
        rd(0, 4, d);
        total++; if (d !== ex[15:0]) $display("FAIL snap_big_hold: got %h want %h", d, ex[15:0]); else passed++;

        program_ch(0, 1000, 0);
        wr(0, 1, 16'h6); st = edge_cnt;
        idle($urandom_range(95, 105));
        wr(0, 5, 16'h0);
        ex = 1000 - (edge_cnt - 1 - st);
        rd(0, 4, d);
        total++; if (d !== ex[15:0]) $display("FAIL snap_l: got %h want %h", d, ex[15:0]); else passed++;
        rd(0, 5, d);
        total++; if (d !== ex[31:16]) $display("FAIL snap_h: got %h want %h", d, ex[31:16]); else passed++;

        q = $urandom_range(200, 900);
        wr(0, 2, 16'(q));
        idle(3);
        rd(0, 0, d);
        total++; if (d !== 16'h0000) $display("FAIL reload_status: got %h want 0000", d); else passed++;
        wr(0, 4, 16'h0);
        rd(0, 4, d);
        total++; if (d !== 16'(q)) $display("FAIL reload_counter: got %h want %h", d, 16'(q)); else passed++;
        idle(10);
        wr(0, 5, 16'h0);
        rd(0, 4, d);
        total++; if (d !== 16'(q)) $display("FAIL reload_stopped: got %h want %h", d, 16'(q)); else passed++;
        rd(0, 5, d);
        total++; if (d !== 16'h0000) $display("FAIL reload_h: got %h want 0000", d); else passed++;
    endtask

    task automatic test_concurrent;
        int p0, st, ev_edge;
        logic [15:0] d;
        do_reset;
        p0 = $urandom_range(8, 20);
        program_ch(0, p0, 0);
        program_ch(3, p0 - 1, 0);
        wr(0, 1, 16'h7); st = edge_cnt;
        wr(3, 1, 16'h7);
        wait_until(st + p0 - 1);
        total++; if (pulse_out !== 4'b0000) $display("FAIL conc_pre_pulse: got %b want 0000", pulse_out); else passed++;
        idle(1);
        total++; if (pulse_out !== 4'b1001) $display("FAIL conc_pulse: got %b want 1001", pulse_out); else passed++;
        idle(1);
        total++; if (irq_vec !== 4'b1001) $display("FAIL conc_irq_vec: got %b want 1001", irq_vec); else passed++;
        total++; if (irq !== 1'b1) $display("FAIL conc_irq: got %b want 1", irq); else passed++;
        wr(0, 0, 16'h0);
        total++; if (irq_vec !== 4'b1000) $display("FAIL conc_clear: got %b want 1000", irq_vec); else passed++;
        ev_edge = st + p0 + (p0 + 1);
        wait_until(ev_edge);
        total++; if (pulse_out[0] !== 1'b1) $display("FAIL conc_second_event: got %b want 1", pulse_out[0]); else passed++;
        wr(0, 0, 16'h0);
        total++; if (irq_vec[0] !== 1'b1) $display("FAIL conc_event_wins_irq: got %b want 1", irq_vec[0]); else passed++;
        rd(0, 0, d);
        total++; if (d[0] !== 1'b1) $display("FAIL conc_event_wins_status: got %h want timeout=1", d); else passed++;
    endtask

    task automatic test_reset_midcount;
        int p;
        logic [15:0] d;
        logic [3:0] seen;
        do_reset;
        p = $urandom_range(4, 9);
        program_ch(1, p, 0);
        wr(1, 1, 16'h7);
        idle(p + 2);
        total++; if (irq !== 1'b1) $display("FAIL midrst_pre_irq: got %b want 1", irq); else passed++;
        rd(1, 2, d);
        total++; if (d !== 16'(p)) $display("FAIL midrst_pre_read: got %h want %h", d, 16'(p)); else passed++;
        reset = 1'b1; address = 5'(1 * 8 + 1); chipselect = 1'b1; write_n = 1'b0; writedata = 16'h5;
        @(posedge clk); #1;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        total++; if ({irq, irq_vec, pulse_out} !== 9'b0) $display("FAIL midrst_outputs: got %b want 0", {irq, irq_vec, pulse_out}); else passed++;
        total++; if (readdata !== 16'h0) $display("FAIL midrst_readdata: got %h want 0", readdata); else passed++;
        rd(1, 0, d);
        total++; if (d !== 16'h0000) $display("FAIL midrst_status: got %h want 0000", d); else passed++;
        rd(1, 1, d);
        total++; if (d !== 16'h0000) $display("FAIL midrst_control: got %h want 0000", d); else passed++;
        rd(1, 2, d);
        total++; if (d !== 16'hC34F) $display("FAIL midrst_period: got %h want c34f", d); else passed++;
        seen = '0;
        repeat (30) begin idle(1); seen |= pulse_out; end
        total++; if (seen !== 4'b0000) $display("FAIL midrst_quiet: got %b want 0000", seen); else passed++;
    endtask

    initial begin
        test_reset;
        test_continuous;
        test_oneshot;
        test_snapshot;
        test_concurrent;
        test_reset_midcount;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
